// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the bit-slice ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    localparam int OP_W = 4;

    function automatic int nslices(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/alu_seq_shreg.sv
// Load / shift-right-by-S register; shift_in enters at the top.
// Operands shift in zeros, the result register shifts in ALU slices.
module alu_seq_shreg #(
    parameter int W = 16,
    parameter int S = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_val,
    input  logic [S-1:0] shift_in,
    output logic [W-1:0] q
);

    logic [W-1:0] shifted;

    generate
        if (W > S) begin : g_wide
            assign shifted = {shift_in, q[W-1:S]};
        end else begin : g_narrow
            assign shifted = shift_in;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/alu_slice_sequencer.sv
// Feeds a SLICE-bit combinational ALU one slice per cycle, LSB first.
// Define ALU_SEQ_BACK2BACK_EN to accept a new request in DONE.
module alu_slice_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    output logic [SLICE-1:0] alu_a,
    output logic [SLICE-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    output logic             alu_cin,
    input  logic [SLICE-1:0] alu_y,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_cout,
    output logic             rsp_zero
);

    localparam int NSLICES = nslices(WIDTH, SLICE);
    localparam int CW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICES - 1);

    generate
        if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_cfg
            $error("WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    seq_state_t state;
    seq_state_t state_n;

    logic [CW-1:0]   cnt;
    logic            carry;
    logic [OP_W-1:0] op;
    logic            accept;
    logic            run;
    logic            done;
    logic            last;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;

    assign run  = (state == RUN);
    assign done = (state == DONE);
    assign last = (cnt == LAST);

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
`ifdef ALU_SEQ_BACK2BACK_EN
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    accept  = req_valid;
                    state_n = req_valid ? RUN : IDLE;
                end
`else
                if (rsp_ready) begin
                    state_n = IDLE;
                end
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            op    <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt   <= '0;
                carry <= req_cin;
                op    <= req_op;
            end else if (run) begin
                cnt   <= cnt + 1'b1;
                carry <= alu_cout;
            end
        end
    end

    // Operands drain to zero after NSLICES shifts, so alu_a/alu_b
    // read back as zero in DONE without extra gating.
    alu_seq_shreg #(.W(WIDTH), .S(SLICE)) u_a_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .shift    (run),
        .load_val (req_a),
        .shift_in ('0),
        .q        (a_q)
    );

    alu_seq_shreg #(.W(WIDTH), .S(SLICE)) u_b_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .shift    (run),
        .load_val (req_b),
        .shift_in ('0),
        .q        (b_q)
    );

    alu_seq_shreg #(.W(WIDTH), .S(SLICE)) u_res_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .shift    (run),
        .load_val ('0),
        .shift_in (alu_y),
        .q        (res_q)
    );

    assign alu_a   = a_q[SLICE-1:0];
    assign alu_b   = b_q[SLICE-1:0];
    assign alu_op  = op;
    assign alu_cin = run & carry;

    assign rsp_valid = done;
    assign rsp_y     = res_q;
    assign rsp_cout  = done & carry;
    assign rsp_zero  = done & ~(|res_q);

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed bench for alu_slice_sequencer with an a+b+cin slice ALU.
// Define ALU_SEQ_BACK2BACK_EN to also exercise back-to-back acceptance.
module tb_alu_slice_sequencer;

    localparam int W = 16;
    localparam int S = 2;
    localparam int N = W / S;
    localparam int unsigned SMASK = (32'd1 << S) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_op = '0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         req_cin = 1'b0;
    logic [S-1:0] alu_a;
    logic [S-1:0] alu_b;
    logic [3:0]   alu_op;
    logic         alu_cin;
    logic [S-1:0] alu_y;
    logic         alu_cout;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_y;
    logic         rsp_cout;
    logic         rsp_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {{S{1'b0}}, alu_cin};
    end

    alu_slice_sequencer #(.WIDTH(W), .SLICE(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_cin   (alu_cin),
        .alu_y     (alu_y),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_cout  (rsp_cout),
        .rsp_zero  (rsp_zero)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [3:0] op,
                          input logic [W-1:0] ey, input logic ec,
                          input int hold, input bit poke);
        int unsigned mask;
        int unsigned c;
        rsp_ready = (hold == 0);
        req_a = a;
        req_b = b;
        req_cin = cin;
        req_op = op;
        req_valid = 1'b1;
        check("idle_ready", 32'(req_ready), 32'd1);
        tick;
        req_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            mask = (32'd1 << (S * k)) - 1;
            c = ((32'(a) & mask) + (32'(b) & mask) + 32'(cin)) >> (S * k);
            if (poke && k == 3) begin
                req_valid = 1'b1;
                req_a = 16'hAAAA;
                req_b = 16'h5555;
            end
            if (k == 4) req_valid = 1'b0;
            check("slice_a", 32'(alu_a), (32'(a) >> (S * k)) & SMASK);
            check("slice_b", 32'(alu_b), (32'(b) >> (S * k)) & SMASK);
            check("slice_cin", 32'(alu_cin), c);
            check("slice_op", 32'(alu_op), 32'(op));
            check("run_ready", 32'(req_ready), 32'd0);
            check("run_valid", 32'(rsp_valid), 32'd0);
            tick;
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_y", 32'(rsp_y), 32'(ey));
        check("rsp_cout", 32'(rsp_cout), 32'(ec));
        check("rsp_zero", 32'(rsp_zero), 32'(ey == '0));
        check("done_alu_a", 32'(alu_a), 32'd0);
        check("done_alu_cin", 32'(alu_cin), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_y", 32'(rsp_y), 32'(ey));
            check("hold_cout", 32'(rsp_cout), 32'(ec));
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick;
        check("after_valid", 32'(rsp_valid), 32'd0);
        check("after_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int gap;
        bit seen;

        rst_n = 1'b0;
        tick;
        tick;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_y", 32'(rsp_y), 32'd0);
        check("rst_cout", 32'(rsp_cout), 32'd0);
        check("rst_zero", 32'(rsp_zero), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_cin", 32'(alu_cin), 32'd0);
        rst_n = 1'b1;
        tick;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_valid", 32'(rsp_valid), 32'd0);

        run_op(16'hFFFF, 16'h0001, 1'b0, 4'h3, 16'h0000, 1'b1, 0, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b1, 4'hA, 16'h5556, 1'b0, 0, 1'b0);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 4'h6, 16'h1000, 1'b0, 5, 1'b1);
        tick;
        check("poke_ignored", 32'(rsp_valid), 32'd0);

        req_a = 16'h00FF;
        req_b = 16'h0F0F;
        req_cin = 1'b1;
        req_op = 4'h5;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        repeat (4) tick;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_alu_op", 32'(alu_op), 32'd0);
        check("abort_alu_cin", 32'(alu_cin), 32'd0);
        check("abort_alu_a", 32'(alu_a), 32'd0);
        tick;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            tick;
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 4'h1, 16'h0002, 1'b0, 0, 1'b0);

`ifdef ALU_SEQ_BACK2BACK_EN
        rsp_ready = 1'b1;
        req_a = 16'h0003;
        req_b = 16'h0004;
        req_cin = 1'b0;
        req_op = 4'h2;
        req_valid = 1'b1;
        tick;
        req_a = 16'h8000;
        req_b = 16'h8000;
        repeat (N) tick;
        check("b2b_valid1", 32'(rsp_valid), 32'd1);
        check("b2b_y1", 32'(rsp_y), 32'h7);
        check("b2b_ready", 32'(req_ready), 32'd1);
        tick;
        req_valid = 1'b0;
        check("b2b_taken", 32'(rsp_valid), 32'd0);
        check("b2b_run_ready", 32'(req_ready), 32'd0);
        gap = 1;
        while (!rsp_valid && gap < 30) begin
            tick;
            gap++;
        end
        check("b2b_gap", 32'(gap), 32'd9);
        check("b2b_y2", 32'(rsp_y), 32'h0);
        check("b2b_cout2", 32'(rsp_cout), 32'd1);
        check("b2b_zero2", 32'(rsp_zero), 32'd1);
        tick;
`else
        gap = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_slice_sequencer.md
# alu_slice_sequencer

Multi-cycle driver that sits directly upstream of the combinational slice ALU. It accepts a full-width operation over a valid/ready request channel, feeds the ALU one SLICE-bit slice per cycle LSB-first while chaining carry, and collects the slice results and final carry-out into a registered response. The sequencer lets a narrow combinational ALU serve WIDTH-bit operations without widening the datapath.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE, otherwise elaboration fails.
- SLICE, 2, slice width of the combinational ALU.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  4  opcode; passed unchanged to every slice.
- req_a, req_b  in  WIDTH  operands.
- req_cin  in  1  carry-in to slice 0.
- alu_a, alu_b  out  SLICE  current slice operands.
- alu_op  out  4  registered opcode.
- alu_cin  out  1  carry into current slice.
- alu_y  in  SLICE  slice result from the ALU; combinational from alu_*.
- alu_cout  in  1  slice carry-out from the ALU.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_y  out  WIDTH  assembled result.
- rsp_cout  out  1  carry-out of the last slice.
- rsp_zero  out  1  rsp_y == 0.

## Operation
- NSLICES = WIDTH/SLICE. A slice counter runs 0..NSLICES-1.
- The FSM has three states: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid, latch op, a, b, cin; clear the counter; go to RUN.
- RUN: req_ready=0.
  - alu_a/alu_b = bits [SLICE*k +: SLICE] of the latched operands, taken from internal shift registers that shift right by SLICE each cycle.
  - alu_cin = latched cin for k=0, otherwise the alu_cout registered from slice k-1.
  - Each edge shifts alu_y into the top of the result register and registers alu_cout.
  - After the edge that captures k=NSLICES-1, go to DONE.
- DONE: rsp_valid=1; rsp_y, rsp_cout, rsp_zero are stable.
  - On rsp_ready, go to IDLE.
  - See Configuration for back-to-back acceptance.
- Requests presented while not ready are ignored. The sequencer never drops or re-orders requests.
- alu_* outputs are driven from registers only, so there is no combinational path from req_* to alu_*. In IDLE and DONE, alu_a, alu_b and alu_cin are 0.
- rsp_zero is computed from the final result register, not accumulated per slice.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_y=0, rsp_cout=0, rsp_zero=0, alu_a=alu_b=0, alu_op=0, alu_cin=0.
- Request accepted at edge T. Slice k is presented during cycle T+1+k. rsp_valid rises after edge T+NSLICES (9th cycle after acceptance for 16/2).
- rsp_valid stays high and rsp_* stay held until rsp_ready is sampled high. Backpressure has unbounded duration.
- Throughput without the macro: one operation per NSLICES+2 cycles when rsp_ready is tied high.
- Reset asserted mid-RUN or mid-DONE aborts immediately to the reset values. The partial result is discarded and no response is produced.
- rsp_ready while rsp_valid=0 has no effect.

## Configuration
- ALU_SEQ_BACK2BACK_EN defined:
  - In DONE, req_ready = rsp_ready.
  - If rsp_ready and req_valid are both high, the response completes and the new request is latched at the same edge, going directly DONE→RUN.
  - Throughput becomes one operation per NSLICES+1 cycles.
- Undefined: req_ready=0 in DONE, and DONE always returns to IDLE.

## Structure
- Package alu_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the opcode width constant (4);
  - function nslices(WIDTH, SLICE).
- One sub-module, alu_seq_shreg: a parameterised load/shift-right-by-SLICE register. It is instantiated twice for the operands, and a shift-in variant is used for the result.
- FSM, counter and carry register stay in the top level.

## Test plan
Test ALU model: alu_y/alu_cout = a+b+cin per slice.
- Reset: hold rst_n=0 → all outputs at reset values, req_ready=1. Release → still IDLE.
- A=0xFFFF, B=0x0001, cin=0 → rsp_y=0x0000, rsp_cout=1, rsp_zero=1. rsp_valid rises 9 cycles after acceptance. alu_cin=1 on slices 1..7.
- A=0x1234, B=0x4321, cin=1 → rsp_y=0x5556, rsp_cout=0, rsp_zero=0. alu_op is constant throughout RUN.
- rsp_ready=0 for 5 cycles in DONE; req_valid pulsed during RUN → response held stable, req_ready=0 in RUN and DONE, the extra request is not accepted.
- rst_n pulsed low at slice 4 → no rsp_valid follows. The next request 0x0001+0x0001 yields 0x0002.
- With ALU_SEQ_BACK2BACK_EN, rsp_ready=1 and two queued requests → the second is accepted on the first's response edge, and responses are 9 cycles apart.
